// File: rtl/desired_drive_pipe_if.sv
// Sample/target bundle between the torque-sensing front end and the
// desired-drive pipeline. The master side supplies rider inputs, the
// slave side (the pipeline) returns the slew-limited target current.
interface desired_drive_pipe_if #(
  parameter int TORQ_W  = 12,
  parameter int INCL_W  = 13,
  parameter int CAD_W   = 5,
  parameter int SCALE_W = 3,
  parameter int OUT_W   = 12
);

  logic               smpl_vld;
  logic [TORQ_W-1:0]  avg_torque;
  logic [CAD_W-1:0]   cadence;
  logic               not_pedaling;
  logic [INCL_W-1:0]  incline;
  logic [SCALE_W-1:0] scale;
  logic               en;
  logic [OUT_W-1:0]   target_curr;
  logic               target_vld;
  logic               raw_sat;

  modport master (
    output smpl_vld, avg_torque, cadence, not_pedaling, incline, scale, en,
    input  target_curr, target_vld, raw_sat
  );

  modport slave (
    input  smpl_vld, avg_torque, cadence, not_pedaling, incline, scale, en,
    output target_curr, target_vld, raw_sat
  );

endinterface

// File: rtl/desired_drive_pipe.sv
// Desired-drive math for the e-bike assist loop: turns rider torque,
// cadence, incline and assist level into a slew-limited motor target
// current. Three register stages: input conditioning, partial products,
// then final product / saturation / slew into the output register.
module desired_drive_pipe #(
  parameter int TORQ_W       = 12,
  parameter int INCL_W       = 13,
  parameter int CAD_W        = 5,
  parameter int SCALE_W      = 3,
  parameter int OUT_W        = 12,
  parameter int TORQUE_MIN   = 'h380,
  parameter int CAD_THRESH   = 1,
  parameter int ASSIST_SHIFT = 15,
  parameter int SLEW_UP      = 'h040,
  parameter int SLEW_DN      = 'h100
) (
  input logic                 clk,
  input logic                 rst,
  desired_drive_pipe_if.slave bus
);

  // Cadence factor must hold cadence+32 for any cadence width.
  localparam int CF_W   = ((CAD_W > 5) ? CAD_W : 5) + 1;
  localparam int TW1    = TORQ_W + 1;
  localparam int PA_W   = TORQ_W + SCALE_W;
  localparam int PB_W   = 9 + CF_W;
  localparam int PROD_W = PA_W + PB_W;

  localparam logic [TW1-1:0]    TMIN    = TW1'(TORQUE_MIN);
  localparam logic [OUT_W-1:0]  UP_STEP = OUT_W'(SLEW_UP);
  localparam logic [OUT_W-1:0]  DN_STEP = OUT_W'(SLEW_DN);
  localparam logic [PROD_W-1:0] RAW_MAX = PROD_W'({OUT_W{1'b1}});

  // Stage 1 conditioning (combinational from the bus)
  logic signed [31:0] incl_ext;
  logic signed [9:0]  incl_sat;
  logic signed [10:0] incl_sum;
  logic [8:0]         incl_lim;
  logic [CF_W-1:0]    cad_factor;
  logic [TW1-1:0]     torque_diff;
  logic [TORQ_W-1:0]  torque_pos;

  // Stage 1 registers
  logic               s1_vld;
  logic [TORQ_W-1:0]  s1_torque;
  logic [SCALE_W-1:0] s1_scale;
  logic [8:0]         s1_incl;
  logic [CF_W-1:0]    s1_cad;
  logic               s1_np;

  // Stage 2 registers
  logic               s2_vld;
  logic [PA_W-1:0]    s2_pa;
  logic [PB_W-1:0]    s2_pb;
  logic               s2_np;

  // Stage 3 / slew (combinational from stage 2 and the output register)
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  prod_shr;
  logic [OUT_W-1:0]   raw;
  logic               raw_ovf;
  logic [OUT_W-1:0]   up_gap;
  logic [OUT_W-1:0]   dn_gap;
  logic [OUT_W-1:0]   tc_next;

  // Output registers
  logic [OUT_W-1:0]   tc_q;
  logic               vld_q;
  logic               sat_q;

  // Clip incline to +-512, shift to a 0..511 gain and form cadence/torque terms
  always_comb begin
    incl_ext = 32'($signed(bus.incline));
    if (incl_ext > 32'sd511) begin
      incl_sat = 10'sd511;
    end else if (incl_ext < -32'sd512) begin
      incl_sat = -10'sd512;
    end else begin
      incl_sat = incl_ext[9:0];
    end

    incl_sum = 11'(incl_sat) + 11'sd256;
    if (incl_sum[10]) begin
      incl_lim = '0;
    end else if (incl_sum[9]) begin
      incl_lim = 9'd511;
    end else begin
      incl_lim = incl_sum[8:0];
    end

    if (32'(bus.cadence) > 32'(CAD_THRESH)) begin
      cad_factor = CF_W'(bus.cadence) + CF_W'(32);
    end else begin
      cad_factor = '0;
    end

    torque_diff = {1'b0, bus.avg_torque} - TMIN;
    torque_pos  = torque_diff[TORQ_W] ? '0 : torque_diff[TORQ_W-1:0];
  end

  // Stage 1 and stage 2 pipeline registers; valid bits march with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_torque <= '0;
      s1_scale  <= '0;
      s1_incl   <= '0;
      s1_cad    <= '0;
      s1_np     <= 1'b0;
      s2_vld    <= 1'b0;
      s2_pa     <= '0;
      s2_pb     <= '0;
      s2_np     <= 1'b0;
    end else begin
      s1_vld <= bus.smpl_vld;
      if (bus.smpl_vld) begin
        s1_torque <= torque_pos;
        s1_scale  <= bus.scale;
        s1_incl   <= incl_lim;
        s1_cad    <= cad_factor;
        s1_np     <= bus.not_pedaling;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_pa <= PA_W'(s1_torque) * PA_W'(s1_scale);
        s2_pb <= PB_W'(s1_incl) * PB_W'(s1_cad);
        s2_np <= s1_np;
      end
    end
  end

  // Final product, saturation to the output width and asymmetric slew step
  always_comb begin
    prod     = PROD_W'(s2_pa) * PROD_W'(s2_pb);
    prod_shr = prod >> ASSIST_SHIFT;
    raw      = '0;
    raw_ovf  = 1'b0;
    if (!s2_np) begin
      if (prod_shr > RAW_MAX) begin
        raw     = {OUT_W{1'b1}};
        raw_ovf = 1'b1;
      end else begin
        raw = prod_shr[OUT_W-1:0];
      end
    end

    up_gap  = raw - tc_q;
    dn_gap  = tc_q - raw;
    tc_next = tc_q;
    if (!bus.en) begin
      tc_next = '0;
    end else if (s2_vld) begin
      if (raw >= tc_q) begin
        tc_next = tc_q + ((up_gap > UP_STEP) ? UP_STEP : up_gap);
      end else begin
        tc_next = tc_q - ((dn_gap > DN_STEP) ? DN_STEP : dn_gap);
      end
    end
  end

  // Output register: target current, its strobe and the saturation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q  <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      tc_q  <= tc_next;
      vld_q <= s2_vld;
      if (s2_vld) begin
        sat_q <= raw_ovf;
      end
    end
  end

  assign bus.target_curr = tc_q;
  assign bus.target_vld  = vld_q;
  assign bus.raw_sat     = sat_q;

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Directed plus randomized bench for desired_drive_pipe. Expected values
// come from a cycle-indexed model: each accepted sample's raw target is
// computed with plain integer arithmetic and scheduled three cycles ahead.
module tb_desired_drive_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  desired_drive_pipe_if bus ();

  desired_drive_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  localparam int DEPTH = 8192;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: output as expected after the upcoming edge
  int m_tc  = 0;
  bit m_vld = 1'b0;
  bit m_sat = 1'b0;

  // Scheduled arrivals, indexed by the cycle in which they become visible
  bit due_vld [DEPTH];
  int due_raw [DEPTH];
  bit due_sat [DEPTH];

  logic [11:0] ramp [6] = '{12'h040, 12'h080, 12'h0C0, 12'h100, 12'h140, 12'h140};

  // Raw target from the rider inputs using ordinary integer arithmetic
  function automatic int modelRaw(input int tq, input int cd, input bit np,
                                  input int inc, input int sc, output bit sat);
    int     inc_c;
    int     lim;
    int     cf;
    int     tp;
    longint prod;
    longint shr;
    sat = 1'b0;
    if (np) return 0;
    inc_c = (inc > 511) ? 511 : ((inc < -512) ? -512 : inc);
    lim   = inc_c + 256;
    if (lim < 0)   lim = 0;
    if (lim > 511) lim = 511;
    cf = (cd > 1) ? cd + 32 : 0;
    tp = tq - 'h380;
    if (tp < 0) tp = 0;
    prod = longint'(tp) * longint'(sc) * longint'(lim) * longint'(cf);
    shr  = prod / 32768;
    if (shr > 4095) begin
      sat = 1'b1;
      return 4095;
    end
    return int'(shr);
  endfunction

  task automatic checkValue(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    checkValue("target_vld", {11'd0, bus.target_vld}, {11'd0, m_vld});
    checkValue("target_curr", bus.target_curr, 12'(m_tc));
    checkValue("raw_sat", {11'd0, bus.raw_sat}, {11'd0, m_sat});
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic applyStimulus(input bit r, input bit v, input logic [11:0] tq,
                               input logic [4:0] cd, input bit np,
                               input logic [12:0] inc, input logic [2:0] sc,
                               input bit e);
    int tgt;
    bit s;
    rst              = r;
    bus.smpl_vld     = v;
    bus.avg_torque   = tq;
    bus.cadence      = cd;
    bus.not_pedaling = np;
    bus.incline      = inc;
    bus.scale        = sc;
    bus.en           = e;

    if (r) begin
      m_tc  = 0;
      m_vld = 1'b0;
      m_sat = 1'b0;
      for (int k = 1; k <= 3; k++) due_vld[cyc + k] = 1'b0;
    end else begin
      if (v) begin
        due_raw[cyc + 3] = modelRaw(int'(tq), int'(cd), np, int'($signed(inc)), int'(sc), s);
        due_sat[cyc + 3] = s;
        due_vld[cyc + 3] = 1'b1;
      end
      m_vld = due_vld[cyc + 1];
      if (m_vld) m_sat = due_sat[cyc + 1];
      if (!e) begin
        m_tc = 0;
      end else if (m_vld) begin
        tgt = due_raw[cyc + 1];
        if (tgt >= m_tc) m_tc = m_tc + (((tgt - m_tc) > 'h040) ? 'h040 : (tgt - m_tc));
        else             m_tc = m_tc - (((m_tc - tgt) > 'h100) ? 'h100 : (m_tc - tgt));
      end
    end

    @(posedge clk);
    #1;
    checkOutput();
    cyc++;
  endtask

  initial begin
    bit          r;
    bit          v;
    logic [11:0] tq;
    logic [4:0]  cd;
    bit          np;
    logic [12:0] inc;
    logic [2:0]  sc;
    bit          e;

    bus.smpl_vld     = 1'b0;
    bus.avg_torque   = '0;
    bus.cadence      = '0;
    bus.not_pedaling = 1'b0;
    bus.incline      = '0;
    bus.scale        = '0;
    bus.en           = 1'b0;
    #1;

    // Reset state
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkValue("reset_curr", bus.target_curr, 12'h000);

    // Basic ramp toward raw = 0x140
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, i < 6, 12'h480, 5'd8, 0, 13'h0000, 3'd4, 1);
      if (i >= 2) checkValue("t1_ramp", bus.target_curr, ramp[i - 2]);
    end

    // Not pedaling ramps down at the faster rate
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, i < 2, 12'h480, 5'd8, 1, 13'h0000, 3'd4, 1);
      if (i == 2) checkValue("t2_down1", bus.target_curr, 12'h040);
      if (i == 3) begin
        checkValue("t2_down2", bus.target_curr, 12'h000);
        checkValue("t2_nosat", {11'd0, bus.raw_sat}, 12'h000);
      end
    end

    // Saturating product climbs to full scale without wrapping
    for (int i = 0; i < 70; i++) begin
      applyStimulus(0, i < 67, 12'hFFF, 5'd31, 0, 13'h0FFF, 3'd7, 1);
    end
    checkValue("t3_top", bus.target_curr, 12'hFFF);
    checkValue("t3_sat", {11'd0, bus.raw_sat}, 12'h001);

    // Zero-gain cases: steep downhill incline and cadence at threshold
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 12'h480, 5'd8, 0, 13'h1ED4, 3'd4, 1);
    checkValue("t4_incline", bus.target_curr, 12'h000);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 12'h480, 5'd1, 0, 13'h0000, 3'd4, 1);
    checkValue("t4_cadence", bus.target_curr, 12'h000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Reset with two samples in flight
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i == 6, i < 6, 12'h480, 5'd8, 0, 13'h0000, 3'd4, 1);
      if (i == 5) checkValue("t5_pre", bus.target_curr, 12'h100);
      if (i >= 6 && i <= 8) begin
        checkValue("t5_curr", bus.target_curr, 12'h000);
        checkValue("t5_novld", {11'd0, bus.target_vld}, 12'h000);
      end
    end

    // Enable drop clears output; re-enable ramps again from zero
    for (int i = 0; i < 8; i++) applyStimulus(0, i < 6, 12'h480, 5'd8, 0, 13'h0000, 3'd4, 1);
    checkValue("t6_hold", bus.target_curr, 12'h140);
    applyStimulus(0, 0, 12'h480, 5'd8, 0, 13'h0000, 3'd4, 0);
    checkValue("t6_off", bus.target_curr, 12'h000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, i < 6, 12'h480, 5'd8, 0, 13'h0000, 3'd4, 1);
      if (i >= 2) checkValue("t6_ramp", bus.target_curr, ramp[i - 2]);
    end

    // Randomized traffic including resets and enable drops
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom % 64) == 0;
      v   = ($urandom % 10) < 7;
      tq  = ($urandom % 2) ? 12'($urandom) : 12'($urandom_range('h700, 'h300));
      cd  = 5'($urandom);
      np  = ($urandom % 8) == 0;
      inc = ($urandom % 2) ? 13'($urandom) : 13'($signed($urandom_range(800, 0)) - 400);
      sc  = 3'($urandom);
      e   = ($urandom % 16) != 0;
      applyStimulus(r, v, tq, cd, np, inc, sc, e);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
